niosii_tutorial_cpu_oci_trace_capture: RTL
==========================================

// Module: niosii_tutorial_cpu_oci_trace_capture
// PURPOSE
//  Parametrised debug-trace capture buffer for the CPU OCI simulation path; generalises the fixed 30-bit/4-bit test-bench hook.
//  Stores tagged trace frames (dct_buffer + dct_count) in a DEPTH-entry buffer, in stop-on-full or wrap mode, and exposes them on a valid/ready read port.
//  On test_ending it stops capture, drains, then asserts a sticky test_has_ended. Sits between the OCI trace source and the bench monitor.
// PARAMETERS
//  DATA_W    30  trace payload width (dct_buffer)
//  CNT_W     4   tag width (dct_count), stored with each frame
//  DEPTH     16  buffer entries; power of 2, >= 2
//  WRAP_MODE 0   0 = stop-on-full (drop newest); 1 = overwrite oldest
// PORTS
//  clk             in   1               single clock, all logic rising-edge
//  reset           in   1               synchronous, active-high
//  arm             in   1               start capture (honoured in IDLE only)
//  dct_valid       in   1               frame present this cycle
//  dct_buffer      in   DATA_W          trace payload
//  dct_count       in   CNT_W           frame tag
//  test_ending     in   1               request end of test (level or pulse)
//  rd_ready        in   1               consumer accepts rd_data
//  rd_valid        out  1               buffer non-empty and readable
//  rd_data         out  CNT_W+DATA_W    {tag, payload} of oldest entry
//  fill_level      out  $clog2(DEPTH)+1 entries held, 0..DEPTH
//  drop_cnt        out  16              frames lost; saturates at 16'hFFFF
//  capturing       out  1               state == CAPTURE
//  test_has_ended  out  1               sticky end flag
// BEHAVIOUR
//  Reset: state IDLE, pointers/fill_level/drop_cnt = 0; all outputs 0. Memory contents are don't-care.
//  States: IDLE -arm-> CAPTURE; CAPTURE -test_ending-> DRAIN;
//    IDLE -test_ending-> DRAIN if fill_level != 0, else ENDED;
//    DRAIN -> ENDED in the cycle after fill_level reaches 0; ENDED holds until reset.
//  test_ending takes priority over arm in IDLE. arm is ignored outside IDLE.
//  Write: accepted only in CAPTURE with dct_valid. A write in the cycle test_ending is sampled is still accepted.
//  Pop: rd_valid && rd_ready. rd_valid = (fill_level != 0) && state != ENDED.
//  Read port is show-ahead: rd_data = mem[rd_ptr]. An entry written in cycle N gives rd_valid in cycle N+1.
//  Full, WRAP_MODE=0:
//    - write without a simultaneous pop: frame discarded, drop_cnt += 1.
//    - write with a simultaneous pop: both happen; fill_level stays DEPTH; no drop.
//  Full, WRAP_MODE=1:
//    - write without a pop: oldest entry overwritten; rd_ptr and wr_ptr both advance; fill_level stays DEPTH; drop_cnt += 1.
//    - write with a pop: normal push + pop; no drop.
//  Empty + write + rd_ready: no bypass. The entry becomes readable next cycle.
//  Pointers are $clog2(DEPTH) bits and wrap naturally. fill_level changes by push - pop (+1, 0, -1) per cycle.
//  drop_cnt saturates at 16'hFFFF and never wraps. It counts in CAPTURE only.
//  test_has_ended = (state == ENDED), registered. It rises the cycle after DRAIN sees fill_level == 0.
//  Reset asserted mid-capture or mid-drain returns the block to IDLE next cycle with the buffer empty; no rd_valid glitch.
//  Inputs dct_buffer/dct_count are don't-care when dct_valid = 0; X on them must not propagate.
// TESTING
//  1. Reset, arm, write tags 0..4 (payload 30'h3FFF_FFF0+i), rd_ready=1 -> read tags 0..4 in order, one per cycle starting 1 cycle after the first write; fill_level back to 0.
//  2. WRAP_MODE=0, DEPTH=16, rd_ready=0, write 20 frames -> fill_level=16, drop_cnt=4; reads return frames 0..15.
//  3. WRAP_MODE=1, same stimulus -> fill_level=16, drop_cnt=4; reads return frames 4..19.
//  4. Full buffer, WRAP_MODE=0, write and pop in the same cycle -> no drop, fill_level=16, next rd_data is the following frame.
//  5. 3 entries held, test_ending pulse, rd_ready=1 -> capturing=0 next cycle, dct_valid ignored, 3 pops, test_has_ended=1 the cycle after empty and stays 1.
//  6. test_ending in IDLE while empty -> test_has_ended=1 after 1 cycle. Then reset mid-CAPTURE with 5 entries -> fill_level=0, rd_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/niosii_tutorial_cpu_oci_trace_capture.sv
// Debug-trace capture buffer for the CPU OCI simulation path.
// Stores {tag, payload} frames in a DEPTH-entry circular buffer and offers
// them on a show-ahead valid/ready read port. The buffer either stops on full
// or overwrites the oldest frame when full. An end-of-test request stops capture,
// lets the buffer drain, then raises a sticky ended flag.
//
// Handshake: a frame leaves the buffer in any cycle where rd_valid_o and
// rd_ready_i are both high. rd_data_o is stable and equals the oldest entry
// while rd_valid_o is high. It reads as zero while rd_valid_o is low.
module niosii_tutorial_cpu_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      arm_i,
  input  logic                      dct_valid_i,
  input  logic [DATA_W-1:0]         dct_buffer_i,
  input  logic [CNT_W-1:0]          dct_count_i,
  input  logic                      test_ending_i,
  input  logic                      rd_ready_i,
  output logic                      rd_valid_o,
  output logic [CNT_W+DATA_W-1:0]   rd_data_o,
  output logic [$clog2(DEPTH):0]    fill_level_o,
  output logic [15:0]               drop_cnt_o,
  output logic                      capturing_o,
  output logic                      test_has_ended_o,
  output logic [1:0]                dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = CNT_W + DATA_W;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam bit WRAP = (WRAP_MODE != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_ENDED   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [15:0]     drop_q, drop_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic rd_valid;
  logic pop;
  logic full;
  logic wr_req;
  logic push;
  logic overwrite;
  logic drop;
  logic advance_rd;

  // Decide this cycle's push/pop/drop from the registered occupancy.
  always_comb begin
    rd_valid   = (fill_q != '0) && (state_q != ST_ENDED);
    pop        = rd_valid && rd_ready_i;
    full       = (fill_q == DEPTH_F);
    wr_req     = (state_q == ST_CAPTURE) && dct_valid_i;
    // When full, a frame goes in if the head frame leaves this cycle or if
    // wrap mode lets it displace the oldest entry.
    push       = wr_req && (!full || pop || WRAP);
    overwrite  = wr_req && full && !pop && WRAP;
    drop       = wr_req && full && !pop;
    advance_rd = pop || overwrite;
  end

  // Next pointers, occupancy and saturating drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(advance_rd);
    fill_d   = fill_q;
    case ({push, advance_rd})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Next-state logic for the capture/drain/ended sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (test_ending_i) begin
          state_d = (fill_q != '0) ? ST_DRAIN : ST_ENDED;
        end else if (arm_i) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (test_ending_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fill_q == '0) begin
          state_d = ST_ENDED;
        end
      end
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset empties the buffer and returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
    end
  end

  // Frame storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_q[wr_ptr_q] <= {dct_count_i, dct_buffer_i};
    end
  end

  assign rd_valid_o       = rd_valid;
  assign rd_data_o        = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign fill_level_o     = fill_q;
  assign drop_cnt_o       = drop_q;
  assign capturing_o      = (state_q == ST_CAPTURE);
  assign test_has_ended_o = (state_q == ST_ENDED);
  assign dbg_state_o      = state_q;

endmodule
